// File: rtl/controlador_elevador_if.sv
// Signal bundle between the elevador controller and its environment:
// call buttons and floor sensors in; motor, door, pending and display code out.
interface controlador_elevador_if;
    logic [3:0] req_btn;
    logic [3:0] floor_sensor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [3:0] pending;
    logic [2:0] disp_code;

    modport master (
        output req_btn, floor_sensor,
        input  motor_up, motor_down, door_open, pending, disp_code
    );

    modport slave (
        input  req_btn, floor_sensor,
        output motor_up, motor_down, door_open, pending, disp_code
    );
endinterface

// File: rtl/controlador_elevador.sv
// Four-floor elevator controller: latches calls, drives the hoist from one-hot
// position sensors, times the door and emits {moving, floor} for the display.
module controlador_elevador #(
    parameter int unsigned DOOR_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    controlador_elevador_if.slave  bus
);

    localparam int unsigned CW = $clog2(DOOR_CYCLES);
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cur_floor_q, cur_floor_d;
    logic          dir_up_q, dir_up_d;
    logic [3:0]    pending_q, pending_d;
    logic [CW-1:0] door_cnt_q, door_cnt_d;

    logic          sensor_valid;
    logic [1:0]    sensor_floor;
    logic [3:0]    above_mask, below_mask;
    logic          any_above, any_below;
    logic [3:0]    set_mask, clr_mask;

    always_comb begin
        sensor_valid = $onehot(bus.floor_sensor);
        sensor_floor = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.floor_sensor[i]) sensor_floor = 2'(i);
        end
    end

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            above_mask[i] = (i > {30'b0, cur_floor_q});
            below_mask[i] = (i < {30'b0, cur_floor_q});
        end
    end

    assign any_above = |(pending_q & above_mask);
    assign any_below = |(pending_q & below_mask);

    always_comb begin
        state_d     = state_q;
        dir_up_d    = dir_up_q;
        door_cnt_d  = door_cnt_q;
        cur_floor_d = sensor_valid ? sensor_floor : cur_floor_q;
        set_mask    = bus.req_btn;
        clr_mask    = '0;

        case (state_q)
            IDLE: begin
                if (pending_q[cur_floor_q]) begin
                    state_d               = DOOR_OPEN;
                    clr_mask[cur_floor_q] = 1'b1;
                    door_cnt_d            = DOOR_LOAD;
                end else if (any_above && any_below) begin
                    state_d = dir_up_q ? MOVE_UP : MOVE_DOWN;
                end else if (any_above) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (any_below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                // Stop decision uses the pending value from before this edge,
                // so a call landing on the arrival edge waits for the next pass.
                if (sensor_valid) begin
                    if (pending_q[sensor_floor]) begin
                        state_d                = DOOR_OPEN;
                        clr_mask[sensor_floor] = 1'b1;
                        door_cnt_d             = DOOR_LOAD;
                    end else if ((state_q == MOVE_UP   && sensor_floor == 2'd3) ||
                                 (state_q == MOVE_DOWN && sensor_floor == 2'd0)) begin
                        state_d = IDLE;
                    end
                end
            end

            DOOR_OPEN: begin
                set_mask[cur_floor_q] = 1'b0;
                if (bus.req_btn[cur_floor_q]) begin
                    door_cnt_d = DOOR_LOAD;
                end else if (door_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    door_cnt_d = door_cnt_q - CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_floor_q <= '0;
            dir_up_q    <= 1'b1;
            pending_q   <= '0;
            door_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            pending_q   <= pending_d;
            door_cnt_q  <= door_cnt_d;
        end
    end

    assign bus.motor_up   = (state_q == MOVE_UP);
    assign bus.motor_down = (state_q == MOVE_DOWN);
    assign bus.door_open  = (state_q == DOOR_OPEN);
    assign bus.pending    = pending_q;
    assign bus.disp_code  = {(state_q == MOVE_UP) || (state_q == MOVE_DOWN), cur_floor_q};

endmodule
